// File: rtl/fetch_if_stage_if.sv
// fetch_if_stage_if: signal bundle between the fetch stage and its environment.
//   master : fetch stage side (drives imem_addr, IF/ID fields, rr, fetch_state)
//   slave  : environment side (hazard unit, later stages, instruction memory)
// Signals:
//   stall, redirect_valid, redirect_pc  - hazard / redirect control into fetch
//   imem_addr, imem_data                - instruction memory address / data
//   for_id, call_id                     - decode flags for the IF/ID instruction
//   if_id_valid/pc/next_pc/instr        - IF/ID pipeline register contents
//   rr                                  - return register
//   fetch_state                         - 0 = RUN, 1 = FOR_HOLD
interface fetch_if_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        for_id;
    logic        call_id;
    logic        if_id_valid;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_next_pc;
    logic [15:0] if_id_instr;
    logic [15:0] rr;
    logic        fetch_state;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_data, for_id, call_id,
        output imem_addr, if_id_valid, if_id_pc, if_id_next_pc, if_id_instr,
               rr, fetch_state
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_data, for_id, call_id,
        input  imem_addr, if_id_valid, if_id_pc, if_id_next_pc, if_id_instr,
               rr, fetch_state
    );
endinterface

// File: rtl/fetch_if_stage.sv
// fetch_if_stage: instruction fetch stage plus IF/ID pipeline register.
// Owns the PC, drives imem_addr combinationally from it, and captures
// {PC, PC+1, instruction} into IF/ID. Handles redirects, external stalls,
// the one-cycle self-stall of For, and the Call return register.
// Ports:
//   CLK  - rising-edge clock
//   RSTn - asynchronous active-low reset
//   bus  - fetch_if_stage_if.master (see interface file for signal list)
module fetch_if_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    fetch_if_stage_if.master      bus
);

    typedef enum logic {RUN = 1'b0, FOR_HOLD = 1'b1} state_t;

    state_t      state, state_next;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic        valid_q;
    logic [15:0] id_pc_q, id_next_pc_q, id_instr_q;
    logic [15:0] rr_q;
    logic        hold;
    logic        for_take;

    // Decode flags only count when IF/ID holds a real instruction.
    assign for_take = bus.for_id && valid_q;
    assign hold     = bus.stall || (state == RUN && for_take);
    assign pc_inc   = pc + 16'd1;   // wraps FFFF -> 0000

    // FSM: next state
    always_comb begin
        state_next = state;
        if (bus.redirect_valid)
            state_next = RUN;               // redirect cancels a pending hold
        else if (state == FOR_HOLD)
            state_next = RUN;               // exactly one extra cycle per For
        else if (for_take && !bus.stall)
            state_next = FOR_HOLD;
    end

    // FSM: state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= RUN;
        else       state <= state_next;
    end

    // PC and IF/ID register: redirect > hold > normal
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pc           <= RESET_PC;
            valid_q      <= 1'b0;
            id_pc_q      <= 16'h0000;
            id_next_pc_q <= 16'h0000;
            id_instr_q   <= NOP_INSTR;
        end else if (bus.redirect_valid) begin
            pc           <= bus.redirect_pc;
            valid_q      <= 1'b0;
            id_pc_q      <= 16'h0000;
            id_next_pc_q <= 16'h0000;
            id_instr_q   <= NOP_INSTR;
        end else if (!hold) begin
            pc           <= pc_inc;
            valid_q      <= 1'b1;
            id_pc_q      <= pc;
            id_next_pc_q <= pc_inc;
            id_instr_q   <= bus.imem_data;
        end
    end

    // Return register. Not gated by redirect: a Call writes RR and
    // redirects on the same edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            rr_q <= 16'h0000;
        else if (bus.call_id && valid_q && !bus.stall)
            rr_q <= id_next_pc_q;
    end

    assign bus.imem_addr     = pc;
    assign bus.if_id_valid   = valid_q;
    assign bus.if_id_pc      = id_pc_q;
    assign bus.if_id_next_pc = id_next_pc_q;
    assign bus.if_id_instr   = id_instr_q;
    assign bus.rr            = rr_q;
    assign bus.fetch_state   = state;

endmodule

// File: tb/tb_fetch_if_stage.sv
// Directed testbench for fetch_if_stage. Instruction memory model returns
// 16'hA000 + address. Inputs change and outputs are sampled 1 time unit
// after the rising edge.
module tb_fetch_if_stage;

    logic CLK = 1'b0;
    logic RSTn;
    int   nchecks = 0;
    int   nerr    = 0;

    fetch_if_stage_if bus ();

    fetch_if_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus.master)
    );

    always #5 CLK = ~CLK;

    assign bus.imem_data = 16'hA000 + bus.imem_addr;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Check a full IF/ID entry plus the current fetch address.
    task automatic chk_ifid(input string tag, input logic v, input logic [15:0] p,
                            input logic [15:0] np, input logic [15:0] ins,
                            input logic [15:0] addr);
        chk({tag, ".valid"},   {15'd0, bus.if_id_valid}, {15'd0, v});
        chk({tag, ".pc"},      bus.if_id_pc,      p);
        chk({tag, ".next_pc"}, bus.if_id_next_pc, np);
        chk({tag, ".instr"},   bus.if_id_instr,   ins);
        chk({tag, ".addr"},    bus.imem_addr,     addr);
    endtask

    task automatic chk_reset(input string tag);
        chk_ifid(tag, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        chk({tag, ".rr"},    bus.rr, 16'h0000);
        chk({tag, ".state"}, {15'd0, bus.fetch_state}, 16'd0);
    endtask

    initial begin
        RSTn = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.for_id = 1'b0;
        bus.call_id = 1'b0;
        #2;
        chk_reset("reset");

        @(negedge CLK);
        RSTn = 1'b1;
        tick(); chk_ifid("seq0", 1'b1, 16'h0000, 16'h0001, 16'hA000, 16'h0001);
        tick(); chk_ifid("seq1", 1'b1, 16'h0001, 16'h0002, 16'hA001, 16'h0002);
        tick(); chk_ifid("seq2", 1'b1, 16'h0002, 16'h0003, 16'hA002, 16'h0003);

        // external stall for 3 cycles
        bus.stall = 1'b1;
        tick(); chk_ifid("stall1", 1'b1, 16'h0002, 16'h0003, 16'hA002, 16'h0003);
        tick();
        tick(); chk_ifid("stall3", 1'b1, 16'h0002, 16'h0003, 16'hA002, 16'h0003);
        bus.stall = 1'b0;
        tick(); chk_ifid("unstall", 1'b1, 16'h0003, 16'h0004, 16'hA003, 16'h0004);
        tick();
        tick(); chk_ifid("seq5", 1'b1, 16'h0005, 16'h0006, 16'hA005, 16'h0006);

        // redirect to 0x0040
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0040;
        tick(); chk_ifid("redir_bub", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0040);
        bus.redirect_valid = 1'b0;
        tick(); chk_ifid("redir_tgt", 1'b1, 16'h0040, 16'h0041, 16'hA040, 16'h0041);

        // get pc 7 into IF/ID
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0007;
        tick();
        bus.redirect_valid = 1'b0;
        tick(); chk_ifid("at7", 1'b1, 16'h0007, 16'h0008, 16'hA007, 16'h0008);
        chk("for.st0", {15'd0, bus.fetch_state}, 16'd0);

        // For at pc 7: one extra hold cycle, for_id ignored in FOR_HOLD
        bus.for_id = 1'b1;
        tick(); chk_ifid("for_hold", 1'b1, 16'h0007, 16'h0008, 16'hA007, 16'h0008);
        chk("for.st1", {15'd0, bus.fetch_state}, 16'd1);
        tick(); chk_ifid("for_done", 1'b1, 16'h0008, 16'h0009, 16'hA008, 16'h0009);
        chk("for.st2", {15'd0, bus.fetch_state}, 16'd0);

        // For again, then redirect during FOR_HOLD
        tick(); chk("for2.st1", {15'd0, bus.fetch_state}, 16'd1);
        bus.for_id = 1'b0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0012;
        tick(); chk_ifid("forredir", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0012);
        chk("forredir.st", {15'd0, bus.fetch_state}, 16'd0);
        bus.redirect_valid = 1'b0;
        tick(); chk_ifid("at12", 1'b1, 16'h0012, 16'h0013, 16'hA012, 16'h0013);

        // Call with simultaneous redirect
        bus.call_id = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0100;
        tick(); chk("call.rr", bus.rr, 16'h0013);
        chk_ifid("call", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
        // call_id on a bubble is ignored
        bus.redirect_valid = 1'b0;
        tick(); chk("callbub.rr", bus.rr, 16'h0013);
        chk_ifid("at100", 1'b1, 16'h0100, 16'h0101, 16'hA100, 16'h0101);
        bus.call_id = 1'b0;

        // stall and redirect together: redirect wins
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'hFFFF;
        tick(); chk_ifid("stall_redir", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;

        // PC wrap
        tick(); chk_ifid("wrap", 1'b1, 16'hFFFF, 16'h0000, 16'h9FFF, 16'h0000);

        // reset asserted mid-FOR_HOLD
        bus.for_id = 1'b1;
        tick(); chk("wrapfor.st", {15'd0, bus.fetch_state}, 16'd1);
        #2;
        RSTn = 1'b0;
        #1;
        chk_reset("midreset");
        bus.for_id = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        tick(); chk_ifid("rerun", 1'b1, 16'h0000, 16'h0001, 16'hA000, 16'h0001);
        chk("rerun.st", {15'd0, bus.fetch_state}, 16'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
